// File: rtl/mem_stage.sv
// Memory/writeback stage: runs load/store/push/pop bus cycles and produces the
// register-file write port and the stack-pointer write port.
module mem_stage #(
    parameter int                 WIDTH  = 32,
    parameter int                 COUNTP = 4,
    parameter logic [COUNTP-1:0]  SPREG  = 4'd15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              exe_valid,
    output logic              exe_ready,
    input  logic [2:0]        exe_op,
    input  logic [1:0]        exe_width,
    input  logic [WIDTH-1:0]  exe_addr,
    input  logic [WIDTH-1:0]  exe_data,
    input  logic [COUNTP-1:0] exe_reg,
    input  logic [WIDTH-1:0]  sp_in,
    output logic              bus_cyc_o,
    output logic              bus_stb_o,
    output logic              bus_we_o,
    output logic [WIDTH-1:0]  bus_adr_o,
    output logic [3:0]        bus_sel_o,
    output logic [WIDTH-1:0]  bus_dat_o,
    input  logic [WIDTH-1:0]  bus_dat_i,
    input  logic              bus_ack_i,
    output logic [COUNTP-1:0] write_addr,
    output logic [WIDTH-1:0]  write_data,
    output logic [1:0]        write_en,
    output logic [WIDTH-1:0]  sp_data_o,
    output logic [1:0]        sp_en,
    output logic              exc_align,
    output logic              state_dbg
);

    // Handshake: an op transfers on a rising edge where exe_valid && exe_ready;
    // exe_ready is high only in IDLE, and the op's fields are only sampled then.
    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    localparam logic [2:0] OP_ALU   = 3'd1;
    localparam logic [2:0] OP_LOAD  = 3'd2;
    localparam logic [2:0] OP_STORE = 3'd3;
    localparam logic [2:0] OP_PUSH  = 3'd4;
    localparam logic [2:0] OP_POP   = 3'd5;

    localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

    state_t              state, state_next;
    logic [2:0]          op_q;
    logic [1:0]          width_q;
    logic [COUNTP-1:0]   reg_q;
    logic [WIDTH-1:0]    sp_q;

    logic                accept;
    logic [1:0]          width_n;
    logic                is_mem;
    logic                is_stack;
    logic                misalign;
    logic                start_bus;
    logic [WIDTH-1:0]    adr_n;
    logic [3:0]          sel_n;
    logic [WIDTH-1:0]    dat_n;
    logic                we_n;
    logic [WIDTH-1:0]    ld_val;

    function automatic logic [WIDTH-1:0] zext(input logic [WIDTH-1:0] v, input logic [1:0] w);
        logic [WIDTH-1:0] r;
        r = v;
        case (w)
            2'd1:    r = {{(WIDTH-8){1'b0}}, v[7:0]};
            2'd2:    r = {{(WIDTH-16){1'b0}}, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    assign exe_ready = (state == IDLE);
    assign bus_cyc_o = (state == BUS);
    assign bus_stb_o = (state == BUS);
    assign state_dbg = state;
    assign accept    = exe_valid & exe_ready;

    // Request decode for the op currently presented by execute.
    always_comb begin
        width_n  = (exe_width == 2'd0) ? 2'd3 : exe_width;
        is_mem   = (exe_op == OP_LOAD) || (exe_op == OP_STORE);
        is_stack = (exe_op == OP_PUSH) || (exe_op == OP_POP);
        misalign = is_mem && (((width_n == 2'd2) && exe_addr[0]) ||
                              ((width_n == 2'd3) && (exe_addr[1:0] != 2'b00)));
        start_bus = accept && ((is_mem && !misalign) || is_stack);
        we_n     = (exe_op == OP_STORE) || (exe_op == OP_PUSH);

        adr_n = exe_addr;
        if (exe_op == OP_PUSH)
            adr_n = sp_in - FOUR;
        else if (exe_op == OP_POP)
            adr_n = sp_in;

        sel_n = 4'b1111;
        if (is_mem) begin
            case (width_n)
                2'd1:    sel_n = 4'b1000 >> exe_addr[1:0];
                2'd2:    sel_n = exe_addr[1] ? 4'b0011 : 4'b1100;
                default: sel_n = 4'b1111;
            endcase
        end

        dat_n = exe_data;
        if (exe_op == OP_STORE) begin
            case (width_n)
                2'd1:    dat_n = {4{exe_data[7:0]}};
                2'd2:    dat_n = {2{exe_data[15:0]}};
                default: dat_n = exe_data;
            endcase
        end
    end

    // Big-endian lane select: address offset 0 is bits 31:24.
    always_comb begin
        ld_val = bus_dat_i;
        case (width_q)
            2'd1: begin
                case (bus_adr_o[1:0])
                    2'd0:    ld_val = zext({{(WIDTH-8){1'b0}}, bus_dat_i[31:24]}, 2'd1);
                    2'd1:    ld_val = zext({{(WIDTH-8){1'b0}}, bus_dat_i[23:16]}, 2'd1);
                    2'd2:    ld_val = zext({{(WIDTH-8){1'b0}}, bus_dat_i[15:8]}, 2'd1);
                    default: ld_val = zext(bus_dat_i, 2'd1);
                endcase
            end
            2'd2:    ld_val = bus_adr_o[1] ? zext(bus_dat_i, 2'd2)
                                           : zext({{(WIDTH-16){1'b0}}, bus_dat_i[31:16]}, 2'd2);
            default: ld_val = bus_dat_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_bus) state_next = BUS;
            BUS:     if (bus_ack_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus request registers and completion pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q       <= '0;
            width_q    <= '0;
            reg_q      <= '0;
            sp_q       <= '0;
            bus_we_o   <= 1'b0;
            bus_adr_o  <= '0;
            bus_sel_o  <= '0;
            bus_dat_o  <= '0;
            write_addr <= '0;
            write_data <= '0;
            write_en   <= '0;
            sp_data_o  <= '0;
            sp_en      <= '0;
            exc_align  <= 1'b0;
        end else begin
            write_en  <= '0;
            sp_en     <= '0;
            exc_align <= 1'b0;
            if (accept) begin
                if (exe_op == OP_ALU) begin
                    write_en   <= width_n;
                    write_addr <= exe_reg;
                    write_data <= zext(exe_data, width_n);
                end else if (misalign) begin
                    exc_align <= 1'b1;
                end else if (start_bus) begin
                    op_q      <= exe_op;
                    width_q   <= is_stack ? 2'd3 : width_n;
                    reg_q     <= exe_reg;
                    sp_q      <= sp_in;
                    bus_we_o  <= we_n;
                    bus_adr_o <= adr_n;
                    bus_sel_o <= sel_n;
                    bus_dat_o <= dat_n;
                end
            end else if ((state == BUS) && bus_ack_i) begin
                case (op_q)
                    OP_LOAD: begin
                        write_en   <= width_q;
                        write_addr <= reg_q;
                        write_data <= ld_val;
                    end
                    OP_PUSH: begin
                        sp_en     <= 2'd3;
                        sp_data_o <= sp_q - FOUR;
                    end
                    OP_POP: begin
                        sp_en <= 2'd3;
                        // Popping into SP itself: the loaded word becomes the new SP.
                        if (reg_q == SPREG) begin
                            sp_data_o <= bus_dat_i;
                        end else begin
                            sp_data_o  <= sp_q + FOUR;
                            write_en   <= 2'd3;
                            write_addr <= reg_q;
                            write_data <= bus_dat_i;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table driven through the stage, with completion
// pulses checked against an expected queue stamped with the cycle they must appear in.
module tb_mem_stage;

  localparam int W = 105;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        exe_valid = 1'b0;
  logic        exe_ready;
  logic [2:0]  exe_op = '0;
  logic [1:0]  exe_width = '0;
  logic [31:0] exe_addr = '0;
  logic [31:0] exe_data = '0;
  logic [3:0]  exe_reg = '0;
  logic [31:0] sp_in = '0;
  logic        bus_cyc_o, bus_stb_o, bus_we_o;
  logic [31:0] bus_adr_o, bus_dat_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_dat_i = '0;
  logic        bus_ack_i = 1'b0;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic [1:0]  write_en;
  logic [31:0] sp_data_o;
  logic [1:0]  sp_en;
  logic        exc_align;
  logic        state_dbg;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  rg;
    logic [31:0] sp;
    logic [31:0] dat_i;
    int          waits;
    logic        bus;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_o;
    logic [1:0]  wen;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  spen;
    logic [31:0] spdata;
    logic        exc;
  } vec_t;

  vec_t vecs[$];

  mem_stage dut (
    .clk_i(clk), .rst_i(rst_i),
    .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_op(exe_op), .exe_width(exe_width),
    .exe_addr(exe_addr), .exe_data(exe_data), .exe_reg(exe_reg), .sp_in(sp_in),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o),
    .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i),
    .write_addr(write_addr), .write_data(write_data), .write_en(write_en),
    .sp_data_o(sp_data_o), .sp_en(sp_en), .exc_align(exc_align), .state_dbg(state_dbg)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc_cnt);
    end
  endtask

  // Expected pulse, due in the cycle after the next rising edge.
  task automatic push_exp(input logic [1:0] wen, input logic [3:0] waddr, input logic [31:0] wdata,
                          input logic [1:0] spen, input logic [31:0] spdata, input logic exc);
    logic [31:0] stamp;
    stamp = 32'(cyc_cnt + 1);
    exp_q.push_back({stamp, wen, waddr, wdata, spen, spdata, exc});
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [1:0] width, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] rg, input logic [31:0] sp,
                              input logic [31:0] dat_i, input int waits, input logic bus,
                              input logic we, input logic [31:0] adr, input logic [3:0] sel,
                              input logic [31:0] dat_o, input logic [1:0] wen, input logic [3:0] waddr,
                              input logic [31:0] wdata, input logic [1:0] spen,
                              input logic [31:0] spdata, input logic exc);
    vec_t v;
    v.op = op; v.width = width; v.addr = addr; v.data = data; v.rg = rg; v.sp = sp;
    v.dat_i = dat_i; v.waits = waits; v.bus = bus; v.we = we; v.adr = adr; v.sel = sel;
    v.dat_o = dat_o; v.wen = wen; v.waddr = waddr; v.wdata = wdata; v.spen = spen;
    v.spdata = spdata; v.exc = exc;
    return v;
  endfunction

  // Scoreboard: every completion pulse must match the head of exp_q in content and cycle.
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic ok;
    if (!rst_i) begin
      while (exp_q.size() > 0 && int'(exp_q[0][104:73]) < cyc_cnt) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_pulse: no pulse observed, expected wen=%0d spen=%0d exc=%0d at cycle %0d",
                 e[72:71], e[34:33], e[0], e[104:73]);
      end
      if (write_en != 2'd0 || sp_en != 2'd0 || exc_align) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: wen=%0d addr=%0d data=0x%08h spen=%0d sp=0x%08h exc=%0d, expected none",
                   write_en, write_addr, write_data, sp_en, sp_data_o, exc_align);
        end else begin
          e = exp_q.pop_front();
          ok = (int'(e[104:73]) == cyc_cnt) && (write_en == e[72:71]) && (sp_en == e[34:33]) &&
               (exc_align == e[0]) &&
               (e[72:71] == 2'd0 || (write_addr == e[70:67] && write_data == e[66:35])) &&
               (e[34:33] == 2'd0 || sp_data_o == e[32:1]);
          if (!ok) begin
            errors++;
            $display("FAIL completion: got wen=%0d addr=%0d data=0x%08h spen=%0d sp=0x%08h exc=%0d cyc=%0d, expected wen=%0d addr=%0d data=0x%08h spen=%0d sp=0x%08h exc=%0d cyc=%0d",
                     write_en, write_addr, write_data, sp_en, sp_data_o, exc_align, cyc_cnt,
                     e[72:71], e[70:67], e[66:35], e[34:33], e[32:1], e[0], e[104:73]);
          end
        end
      end
    end
  end

  // Driver: called at a falling edge, returns at the falling edge where any pulse is visible.
  task automatic run_vec(input vec_t v);
    int busy;
    chk("ready_before_op", 32'(exe_ready), 32'd1);
    exe_valid = 1'b1; exe_op = v.op; exe_width = v.width; exe_addr = v.addr;
    exe_data = v.data; exe_reg = v.rg; sp_in = v.sp;
    if (!v.bus && (v.wen != 2'd0 || v.spen != 2'd0 || v.exc))
      push_exp(v.wen, v.waddr, v.wdata, v.spen, v.spdata, v.exc);
    @(negedge clk);
    exe_valid = 1'b0;
    sp_in = $urandom;
    if (!v.bus) begin
      chk("no_bus_cyc", 32'(bus_cyc_o), 32'd0);
      chk("ready_stays", 32'(exe_ready), 32'd1);
    end else begin
      chk("bus_cyc", 32'(bus_cyc_o), 32'd1);
      chk("bus_stb", 32'(bus_stb_o), 32'd1);
      chk("bus_we", 32'(bus_we_o), 32'(v.we));
      chk("bus_adr", bus_adr_o, v.adr);
      chk("bus_sel", 32'(bus_sel_o), 32'(v.sel));
      if (v.we) chk("bus_dat_o", bus_dat_o, v.dat_o);
      busy = exe_ready ? 0 : 1;
      for (int i = 0; i < v.waits; i++) begin
        @(negedge clk);
        if (!exe_ready && bus_cyc_o) busy++;
      end
      chk("busy_cycles", 32'(busy), 32'(v.waits + 1));
      chk("bus_adr_stable", bus_adr_o, v.adr);
      chk("bus_sel_stable", 32'(bus_sel_o), 32'(v.sel));
      bus_ack_i = 1'b1;
      bus_dat_i = v.dat_i;
      if (v.wen != 2'd0 || v.spen != 2'd0)
        push_exp(v.wen, v.waddr, v.wdata, v.spen, v.spdata, 1'b0);
      @(negedge clk);
      bus_ack_i = 1'b0;
      bus_dat_i = $urandom;
      chk("cyc_after_ack", 32'(bus_cyc_o), 32'd0);
      chk("ready_after_ack", 32'(exe_ready), 32'd1);
    end
  endtask

  initial begin
    // op, width, addr, data, reg, sp, dat_i, waits, bus, we, adr, sel, dat_o, wen, waddr, wdata, spen, spdata, exc
    vecs.push_back(mk(3'd1, 2'd3, 32'h0, 32'h12345678, 4'd3, 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 2'd3, 4'd3, 32'h12345678, 2'd0, 32'h0, 1'b0));
    vecs.push_back(mk(3'd1, 2'd3, 32'h0, 32'h0BADF00D, 4'd4, 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 2'd3, 4'd4, 32'h0BADF00D, 2'd0, 32'h0, 1'b0));
    vecs.push_back(mk(3'd1, 2'd1, 32'h0, 32'hCAFE01A5, 4'd7, 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 2'd1, 4'd7, 32'h000000A5, 2'd0, 32'h0, 1'b0));
    vecs.push_back(mk(3'd1, 2'd2, 32'h0, 32'hCAFEBEEF, 4'd5, 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 2'd2, 4'd5, 32'h0000BEEF, 2'd0, 32'h0, 1'b0));
    vecs.push_back(mk(3'd1, 2'd0, 32'h0, 32'h89ABCDEF, 4'd6, 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 2'd3, 4'd6, 32'h89ABCDEF, 2'd0, 32'h0, 1'b0));
    vecs.push_back(mk(3'd0, 2'd3, 32'h0, 32'hFFFFFFFF, 4'd1, 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 2'd0, 4'd0, 32'h0, 2'd0, 32'h0, 1'b0));
    vecs.push_back(mk(3'd2, 2'd1, 32'h1001, 32'h0, 4'd1, 32'h0, 32'hAABBCCDD, 2, 1'b1, 1'b0, 32'h1001, 4'b0100, 32'h0, 2'd1, 4'd1, 32'h000000BB, 2'd0, 32'h0, 1'b0));
    vecs.push_back(mk(3'd2, 2'd2, 32'h2002, 32'h0, 4'd8, 32'h0, 32'hAABBCCDD, 0, 1'b1, 1'b0, 32'h2002, 4'b0011, 32'h0, 2'd2, 4'd8, 32'h0000CCDD, 2'd0, 32'h0, 1'b0));
    vecs.push_back(mk(3'd2, 2'd2, 32'h2000, 32'h0, 4'd11, 32'h0, 32'hAABBCCDD, 1, 1'b1, 1'b0, 32'h2000, 4'b1100, 32'h0, 2'd2, 4'd11, 32'h0000AABB, 2'd0, 32'h0, 1'b0));
    vecs.push_back(mk(3'd2, 2'd3, 32'h3000, 32'h0, 4'd9, 32'h0, 32'h01020304, 1, 1'b1, 1'b0, 32'h3000, 4'b1111, 32'h0, 2'd3, 4'd9, 32'h01020304, 2'd0, 32'h0, 1'b0));
    vecs.push_back(mk(3'd2, 2'd1, 32'h0013, 32'h0, 4'd10, 32'h0, 32'hAABBCCDD, 0, 1'b1, 1'b0, 32'h0013, 4'b0001, 32'h0, 2'd1, 4'd10, 32'h000000DD, 2'd0, 32'h0, 1'b0));
    vecs.push_back(mk(3'd3, 2'd1, 32'h4002, 32'h9876545A, 4'd1, 32'h0, 32'h0, 1, 1'b1, 1'b1, 32'h4002, 4'b0010, 32'h5A5A5A5A, 2'd0, 4'd0, 32'h0, 2'd0, 32'h0, 1'b0));
    vecs.push_back(mk(3'd3, 2'd3, 32'h4004, 32'h11223344, 4'd1, 32'h0, 32'h0, 0, 1'b1, 1'b1, 32'h4004, 4'b1111, 32'h11223344, 2'd0, 4'd0, 32'h0, 2'd0, 32'h0, 1'b0));
    vecs.push_back(mk(3'd4, 2'd3, 32'h0, 32'hDEADBEEF, 4'd1, 32'h1000, 32'h0, 1, 1'b1, 1'b1, 32'h0FFC, 4'b1111, 32'hDEADBEEF, 2'd0, 4'd0, 32'h0, 2'd3, 32'h0FFC, 1'b0));
    vecs.push_back(mk(3'd5, 2'd3, 32'h0, 32'h0, 4'd2, 32'h0FFC, 32'hCAFEF00D, 0, 1'b1, 1'b0, 32'h0FFC, 4'b1111, 32'h0, 2'd3, 4'd2, 32'hCAFEF00D, 2'd3, 32'h1000, 1'b0));
    vecs.push_back(mk(3'd5, 2'd3, 32'h0, 32'h0, 4'd15, 32'h2000, 32'hCAFEF00D, 1, 1'b1, 1'b0, 32'h2000, 4'b1111, 32'h0, 2'd0, 4'd0, 32'h0, 2'd3, 32'hCAFEF00D, 1'b0));
    vecs.push_back(mk(3'd4, 2'd1, 32'h0, 32'h00000001, 4'd1, 32'h0, 32'h0, 0, 1'b1, 1'b1, 32'hFFFFFFFC, 4'b1111, 32'h00000001, 2'd0, 4'd0, 32'h0, 2'd3, 32'hFFFFFFFC, 1'b0));
    vecs.push_back(mk(3'd5, 2'd3, 32'h0, 32'h0, 4'd12, 32'hFFFFFFFC, 32'h13579BDF, 0, 1'b1, 1'b0, 32'hFFFFFFFC, 4'b1111, 32'h0, 2'd3, 4'd12, 32'h13579BDF, 2'd3, 32'h0, 1'b0));
    vecs.push_back(mk(3'd2, 2'd2, 32'h1003, 32'h0, 4'd1, 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 2'd0, 4'd0, 32'h0, 2'd0, 32'h0, 1'b1));
    vecs.push_back(mk(3'd3, 2'd3, 32'h2001, 32'h55, 4'd1, 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 2'd0, 4'd0, 32'h0, 2'd0, 32'h0, 1'b1));
    vecs.push_back(mk(3'd2, 2'd0, 32'h2002, 32'h0, 4'd1, 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 2'd0, 4'd0, 32'h0, 2'd0, 32'h0, 1'b1));
    vecs.push_back(mk(3'd6, 2'd3, 32'h1000, 32'h77, 4'd1, 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 2'd0, 4'd0, 32'h0, 2'd0, 32'h0, 1'b0));
    vecs.push_back(mk(3'd3, 2'd2, 32'h2002, 32'h00001234, 4'd1, 32'h0, 32'h0, 0, 1'b1, 1'b1, 32'h2002, 4'b0011, 32'h12341234, 2'd0, 4'd0, 32'h0, 2'd0, 32'h0, 1'b0));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(exe_ready), 32'd1);
    chk("rst_cyc", 32'(bus_cyc_o), 32'd0);
    chk("rst_stb", 32'(bus_stb_o), 32'd0);
    chk("rst_we", 32'(bus_we_o), 32'd0);
    chk("rst_adr", bus_adr_o, 32'd0);
    chk("rst_sel", 32'(bus_sel_o), 32'd0);
    chk("rst_dat_o", bus_dat_o, 32'd0);
    chk("rst_write_en", 32'(write_en), 32'd0);
    chk("rst_write_addr", 32'(write_addr), 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_sp_en", 32'(sp_en), 32'd0);
    chk("rst_sp_data", sp_data_o, 32'd0);
    chk("rst_exc", 32'(exc_align), 32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // Table: consecutive entries are issued back to back with no idle cycle.
    foreach (vecs[i]) run_vec(vecs[i]);

    // Random back-to-back ALU ops against a small zero-extension model.
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      logic [1:0]  w;
      logic [31:0] d, m;
      w = 2'($urandom_range(0, 3));
      d = $urandom;
      m = (w == 2'd1) ? (d & 32'h000000FF) : (w == 2'd2) ? (d & 32'h0000FFFF) : d;
      v = mk(3'd1, w, 32'h0, d, 4'($urandom_range(0, 15)), 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0,
             32'h0, (w == 2'd0) ? 2'd3 : w, 4'd0, m, 2'd0, 32'h0, 1'b0);
      v.waddr = v.rg;
      run_vec(v);
    end

    // Ack while idle must be ignored.
    bus_ack_i = 1'b1;
    bus_dat_i = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    bus_ack_i = 1'b0;
    chk("idle_ack_cyc", 32'(bus_cyc_o), 32'd0);
    chk("idle_ack_ready", 32'(exe_ready), 32'd1);

    // Reset asserted while a store waits for ack.
    exe_valid = 1'b1; exe_op = 3'd3; exe_width = 2'd2; exe_addr = 32'h2002;
    exe_data = 32'h00001234; exe_reg = 4'd1;
    @(negedge clk);
    exe_valid = 1'b0;
    chk("rststore_cyc", 32'(bus_cyc_o), 32'd1);
    chk("rststore_sel", 32'(bus_sel_o), 32'b0011);
    chk("rststore_dat", bus_dat_o, 32'h12341234);
    chk("rststore_state", 32'(state_dbg), 32'd1);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk("rst_drops_cyc", 32'(bus_cyc_o), 32'd0);
    chk("rst_drops_stb", 32'(bus_stb_o), 32'd0);
    bus_ack_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    bus_ack_i = 1'b0;
    chk("rst_release_ready", 32'(exe_ready), 32'd1);
    chk("rst_release_cyc", 32'(bus_cyc_o), 32'd0);
    repeat (3) @(negedge clk);

    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
